// File: rtl/adc_spi_scan.sv
// MCP320x SPI scan master: one CS frame per channel, walking ch_mask once or continuously.
// data_valid pulses on the clk after the last SCK fall; no backpressure, data_read is overwritten by the next frame.
module adc_spi_scan #(
    parameter int NUM_CH    = 2,
    parameter int RES       = 12,
    parameter int NULL_BITS = 1,
    parameter int HALF_DIV  = 4,
    parameter int CS_IDLE   = 4,
    localparam int CH_BITS  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cont,
    input  logic               diff_mode,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic               sdi,
    output logic               sck,
    output logic               sdo,
    output logic               chip_en,
    output logic               busy,
    output logic [RES-1:0]     data_read,
    output logic [CH_BITS-1:0] data_ch,
    output logic               data_valid
);

    localparam int CMD_LEN   = 2 + CH_BITS + ((CH_BITS == 1) ? 1 : 0);
    localparam int FRAME     = CMD_LEN + NULL_BITS + RES;
    localparam int CNT_W     = $clog2(FRAME + 1);
    localparam int DESEL_CLK = CS_IDLE * HALF_DIV;
    localparam int DIV_W     = $clog2(DESEL_CLK + HALF_DIV + 1);

    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(HALF_DIV - 1);
    localparam logic [DIV_W-1:0] DESEL_LAST = DIV_W'(DESEL_CLK - 1);
    localparam logic [CNT_W-1:0] FRAME_C    = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] DATA_FROM  = CNT_W'(CMD_LEN + NULL_BITS);

    typedef enum logic [1:0] {IDLE, SELECT, SHIFT, DESEL} state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [NUM_CH-1:0]   mask_q;
    logic                diff_q;
    logic [CH_BITS-1:0]  ch_idx;
    logic [RES-1:0]      shift_reg;
    logic [CMD_LEN-1:0]  cmd_word, cmd_sh;
    logic [CH_BITS-1:0]  low_idx, next_idx;
    logic                has_next;
    logic                half_end, desel_end;

    assign half_end  = (div_cnt == HALF_LAST);
    assign desel_end = (div_cnt == DESEL_LAST);

    // Command bit k goes out after falling edge k, so shifting by the rise count selects it.
    always_comb begin
        cmd_word = '0;
        cmd_word[CMD_LEN-1] = 1'b1;
        cmd_word[CMD_LEN-2] = ~diff_q;
        cmd_word[CMD_LEN-3 -: CH_BITS] = ch_idx;
        if (CH_BITS == 1) cmd_word[0] = 1'b1;
        cmd_sh = cmd_word << bit_cnt;
    end

    always_comb begin
        low_idx  = '0;
        next_idx = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) low_idx = CH_BITS'(i);
            if (mask_q[i] && (i > int'(ch_idx))) begin
                has_next = 1'b1;
                next_idx = CH_BITS'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (|ch_mask)) state_nxt = SELECT;
            SELECT:  if (half_end) state_nxt = SHIFT;
            SHIFT:   if (half_end && sck && (bit_cnt == FRAME_C)) state_nxt = DESEL;
            DESEL:   if (desel_end) state_nxt = (has_next || (cont && (|ch_mask))) ? SELECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck        <= 1'b0;
            sdo        <= 1'b0;
            chip_en    <= 1'b1;
            busy       <= 1'b0;
            data_read  <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            mask_q     <= '0;
            diff_q     <= 1'b0;
            ch_idx     <= '0;
            shift_reg  <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (state_nxt == SELECT) begin
                        mask_q  <= ch_mask;
                        diff_q  <= diff_mode;
                        ch_idx  <= low_idx;
                        busy    <= 1'b1;
                        chip_en <= 1'b0;
                        sdo     <= 1'b1;
                    end
                end
                SELECT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        sck     <= 1'b1;
                        bit_cnt <= CNT_W'(1);
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt >= DATA_FROM) shift_reg <= {shift_reg[RES-2:0], sdi};
                        end else begin
                            sdo <= cmd_sh[CMD_LEN-1];
                            if (state_nxt == DESEL) begin
                                chip_en    <= 1'b1;
                                data_read  <= shift_reg;
                                data_ch    <= ch_idx;
                                data_valid <= 1'b1;
                                bit_cnt    <= '0;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DESEL: begin
                    if (desel_end) begin
                        div_cnt <= '0;
                        if (state_nxt == SELECT) begin
                            chip_en <= 1'b0;
                            sdo     <= 1'b1;
                            if (has_next) begin
                                ch_idx <= next_idx;
                            end else begin
                                mask_q <= ch_mask;
                                diff_q <= diff_mode;
                                ch_idx <= low_idx;
                            end
                        end else begin
                            busy <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_scan.sv
// Directed bench for adc_spi_scan: two DUTs (2-ch MCP3202, 8-ch MCP3208) each driven by a behavioural ADC.
// Expected frames are queued at stimulus time and checked when data_valid fires.
module tb_adc_spi_scan;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, cont_a = 1'b0, diff_a = 1'b0, sdi_a = 1'b0;
    logic [1:0]  mask_a = '0;
    logic        sck_a, sdo_a, cs_a, busy_a, dv_a;
    logic [11:0] dr_a;
    logic [0:0]  dch_a;

    logic        start_b = 1'b0, cont_b = 1'b0, diff_b = 1'b0, sdi_b = 1'b0;
    logic [7:0]  mask_b = '0;
    logic        sck_b, sdo_b, cs_b, busy_b, dv_b;
    logic [11:0] dr_b;
    logic [2:0]  dch_b;

    adc_spi_scan u_a (
        .clk(clk), .reset(reset), .start(start_a), .cont(cont_a), .diff_mode(diff_a),
        .ch_mask(mask_a), .sdi(sdi_a), .sck(sck_a), .sdo(sdo_a), .chip_en(cs_a),
        .busy(busy_a), .data_read(dr_a), .data_ch(dch_a), .data_valid(dv_a)
    );

    adc_spi_scan #(.NUM_CH(8), .NULL_BITS(2)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .cont(cont_b), .diff_mode(diff_b),
        .ch_mask(mask_b), .sdi(sdi_b), .sck(sck_b), .sdo(sdo_b), .chip_en(cs_b),
        .busy(busy_b), .data_read(dr_b), .data_ch(dch_b), .data_valid(dv_b)
    );

    // ADC models: capture DIN on SCK rise, present DOUT after SCK fall.
    logic [11:0] val_a [2];
    logic [11:0] val_b = '0;
    int          na = 0, nb = 0;
    logic [4:0]  cmd_sr_a = '0, cmd_sr_b = '0, last_cmd_a = '0, last_cmd_b = '0;
    int          last_rises_a = 0, last_rises_b = 0;
    logic [11:0] tmp_a, tmp_b;

    always @(posedge sck_a or negedge sck_a or posedge cs_a) begin
        if (cs_a) begin
            if (na != 0) begin
                last_rises_a = na;
                last_cmd_a   = cmd_sr_a;
            end
            na = 0; cmd_sr_a = '0; sdi_a = 1'b0;
        end else if (sck_a) begin
            na++;
            if (na <= 4) cmd_sr_a = {cmd_sr_a[3:0], sdo_a};
        end else if (na >= 5 && na < 17) begin
            tmp_a = val_a[cmd_sr_a[1]] << (na - 5);
            sdi_a = tmp_a[11];
        end else begin
            sdi_a = 1'b0;
        end
    end

    always @(posedge sck_b or negedge sck_b or posedge cs_b) begin
        if (cs_b) begin
            if (nb != 0) begin
                last_rises_b = nb;
                last_cmd_b   = cmd_sr_b;
            end
            nb = 0; cmd_sr_b = '0; sdi_b = 1'b0;
        end else if (sck_b) begin
            nb++;
            if (nb <= 5) cmd_sr_b = {cmd_sr_b[3:0], sdo_b};
        end else if (nb >= 7 && nb < 19) begin
            tmp_b = val_b << (nb - 7);
            sdi_b = tmp_b[11];
        end else begin
            sdi_b = 1'b0;
        end
    end

    int dvc_a = 0, dvc_b = 0, hi_run = 0, gap_a = 0;
    always @(negedge clk) begin
        if (dv_a) dvc_a++;
        if (dv_b) dvc_b++;
        if (cs_a) hi_run++;
        else begin
            if (hi_run != 0) gap_a = hi_run;
            hi_run = 0;
        end
    end

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] data;
        logic [4:0]  cmd;
        int          rises;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    int vectors = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    // Waits (bounded) for the next data_valid of one DUT and checks it against the queue head.
    task automatic frame(input string tag, input bit inst);
        int   t;
        logic got;
        bit   have;
        exp_t e;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(inst ? dv_b : dv_a) && t < 4000);
        got = inst ? dv_b : dv_a;
        chk({tag, "_valid"}, 32'(got), 32'd1);
        if (got) begin
            have = inst ? (q_b.size() != 0) : (q_a.size() != 0);
            chk({tag, "_queued"}, 32'(have), 32'd1);
            if (have) begin
                if (inst) e = q_b.pop_front();
                else      e = q_a.pop_front();
                chk({tag, "_data"},  inst ? 32'(dr_b) : 32'(dr_a), 32'(e.data));
                chk({tag, "_ch"},    inst ? 32'(dch_b) : 32'(dch_a), 32'(e.ch));
                chk({tag, "_cmd"},   inst ? 32'(last_cmd_b) : 32'(last_cmd_a), 32'(e.cmd));
                chk({tag, "_rises"}, inst ? 32'(last_rises_b) : 32'(last_rises_a), 32'(e.rises));
            end
        end
    endtask

    initial begin
        int c0, t;
        val_a[0] = 12'hA5C;
        val_a[1] = 12'h3C7;
        val_b    = 12'h7FF;

        repeat (2) @(negedge clk);
        chk("rst_sck", 32'(sck_a), 32'd0);
        chk("rst_sdo", 32'(sdo_a), 32'd0);
        chk("rst_cs", 32'(cs_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_dv", 32'(dv_a), 32'd0);
        chk("rst_data", 32'(dr_a), 32'd0);
        chk("rst_ch", 32'(dch_a), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single-ended ch0, single scan
        mask_a = 2'b01; diff_a = 1'b0; cont_a = 1'b0;
        q_a.push_back('{ch: 3'd0, data: 12'hA5C, cmd: 5'b01101, rises: 17});
        c0 = dvc_a;
        pulse_a();
        frame("se_ch0", 1'b0);
        repeat (15) @(negedge clk);
        chk("busy_hold", 32'(busy_a), 32'd1);
        @(negedge clk);
        chk("busy_drop", 32'(busy_a), 32'd0);
        chk("cs_idle", 32'(cs_a), 32'd1);
        repeat (100) @(negedge clk);
        chk("se_one_dv", 32'(dvc_a - c0), 32'd1);

        // Differential ch1 only
        mask_a = 2'b10; diff_a = 1'b1;
        q_a.push_back('{ch: 3'd1, data: 12'h3C7, cmd: 5'b01011, rises: 17});
        c0 = dvc_a;
        pulse_a();
        frame("diff_ch1", 1'b0);
        repeat (120) @(negedge clk);
        chk("diff_one_dv", 32'(dvc_a - c0), 32'd1);
        chk("diff_busy", 32'(busy_a), 32'd0);

        // Continuous scan over both channels, then drop cont during the second scan
        val_a[0] = 12'h123; val_a[1] = 12'hFED;
        mask_a = 2'b11; diff_a = 1'b0; cont_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q_a.push_back('{ch: 3'd0, data: 12'h123, cmd: 5'b01101, rises: 17});
            q_a.push_back('{ch: 3'd1, data: 12'hFED, cmd: 5'b01111, rises: 17});
        end
        pulse_a();
        frame("cont0", 1'b0);
        frame("cont1", 1'b0);
        vectors++;
        assert (gap_a >= 16) else begin
            fails++;
            $error("FAIL gap_between_ch: observed %0d expected >=16", gap_a);
        end
        frame("cont2", 1'b0);
        vectors++;
        assert (gap_a >= 16) else begin
            fails++;
            $error("FAIL gap_restart: observed %0d expected >=16", gap_a);
        end
        cont_a = 1'b0;
        mask_a = 2'b01;
        frame("cont3", 1'b0);
        t = 0;
        while (busy_a && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("cont_stop_busy", 32'(busy_a), 32'd0);
        chk("cont_stop_cs", 32'(cs_a), 32'd1);
        c0 = dvc_a;
        repeat (300) @(negedge clk);
        chk("cont_no_restart", 32'(dvc_a - c0), 32'd0);

        // Empty mask is ignored
        mask_a = 2'b00;
        pulse_a();
        repeat (3) @(negedge clk);
        chk("empty_busy", 32'(busy_a), 32'd0);
        chk("empty_cs", 32'(cs_a), 32'd1);
        repeat (40) @(negedge clk);
        chk("empty_cs_late", 32'(cs_a), 32'd1);
        chk("empty_no_dv", 32'(dvc_a - c0), 32'd0);

        // Asynchronous reset in the middle of SHIFT
        val_a[0] = 12'hA5C;
        mask_a = 2'b01;
        pulse_a();
        t = 0;
        while (na < 9 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("reach_bit9", 32'(na >= 9), 32'd1);
        c0 = dvc_a;
        #2 reset = 1'b0;
        #1;
        chk("arst_cs", 32'(cs_a), 32'd1);
        chk("arst_sck", 32'(sck_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_data", 32'(dr_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("arst_no_dv", 32'(dvc_a - c0), 32'd0);
        chk("arst_data_kept", 32'(dr_a), 32'd0);

        // 8-channel part, two null bits, ch5
        mask_b = 8'h20;
        q_b.push_back('{ch: 3'd5, data: 12'h7FF, cmd: 5'b11101, rises: 19});
        c0 = dvc_b;
        pulse_b();
        frame("b_ch5", 1'b1);
        repeat (40) @(negedge clk);
        chk("b_busy", 32'(busy_b), 32'd0);
        chk("b_one_dv", 32'(dvc_b - c0), 32'd1);

        chk("q_a_drained", 32'(q_a.size()), 32'd0);
        chk("q_b_drained", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
